// File: rtl/demux8to16_deser.sv
// Receive-side deserializer: rebuilds lane1/lane2 word pairs from an alternating
// word stream and hands each completed pair off with a valid/ready handshake.
module demux8to16_deser #(
    parameter int W         = 8,
    parameter bit FIRST_SEL = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [W-1:0]     i_in,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_sel,
    output logic [W-1:0]     o_out1,
    output logic [W-1:0]     o_out2,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [CNT_W-1:0] o_pair_cnt
);

    typedef enum logic [1:0] {
        S_WAIT_A = 2'd0,
        S_WAIT_B = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_out1;
    logic [W-1:0]       r_out2;
    logic [CNT_W-1:0]   r_pair_cnt;
    logic               w_in_xfer;
    logic               w_out_xfer;

    // flush cancels both handshakes for the cycle it is asserted
    assign w_in_xfer  = i_in_valid & o_in_ready & ~i_flush;
    assign w_out_xfer = o_out_valid & i_out_ready & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_WAIT_A;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = S_WAIT_A;
        end else begin
            case (r_state)
                S_WAIT_A: if (w_in_xfer) w_next = S_WAIT_B;
                S_WAIT_B: if (w_in_xfer) w_next = S_FULL;
                S_FULL:   if (w_out_xfer) w_next = w_in_xfer ? S_WAIT_B : S_WAIT_A;
                default:  w_next = S_WAIT_A;
            endcase
        end
    end

    // in FULL the next word can only enter on the hand-off edge, so the lane
    // registers are never disturbed while a pair is waiting
    always_comb begin
        o_out_valid = (r_state == S_FULL);
        o_in_ready  = (r_state != S_FULL) | i_out_ready;
        o_sel       = (r_state == S_WAIT_B) ? ~FIRST_SEL : FIRST_SEL;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out1     <= '0;
            r_out2     <= '0;
            r_pair_cnt <= '0;
        end else begin
            if (w_in_xfer) begin
                if (o_sel) r_out2 <= i_in;
                else       r_out1 <= i_in;
            end
            if (w_out_xfer) r_pair_cnt <= r_pair_cnt + CNT_W'(1);
        end
    end

    assign o_out1     = r_out1;
    assign o_out2     = r_out2;
    assign o_pair_cnt = r_pair_cnt;

endmodule

// File: tb/tb_demux8to16_deser.sv
// Bench for demux8to16_deser: table-driven pair stream, scoreboard on hand-off,
// plus hand sequences for backpressure, flush, reset and counter wrap.
module tb_demux8to16_deser;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] exp_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_w;
    logic       in_ready, sel, out_valid;
    logic [7:0] out1, out2;
    logic [3:0] pair_cnt;

    logic       fs_in_valid, fs_out_ready;
    logic [7:0] fs_in;
    logic       fs_in_ready, fs_sel, fs_out_valid;
    logic [7:0] fs_out1, fs_out2;
    logic [15:0] fs_pair_cnt;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    stalls = 0;
    logic [3:0] m_cnt = '0;
    pair_t q[$];

    always #5 clk = ~clk;

    demux8to16_deser #(.W(8), .FIRST_SEL(1'b0), .CNT_W(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in(in_w), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_sel(sel), .o_out1(out1), .o_out2(out2),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_pair_cnt(pair_cnt)
    );

    demux8to16_deser #(.W(8), .FIRST_SEL(1'b1), .CNT_W(16)) u_fs (
        .i_clk(clk), .i_rst(rst), .i_flush(1'b0), .i_in(fs_in), .i_in_valid(fs_in_valid),
        .o_in_ready(fs_in_ready), .o_sel(fs_sel), .o_out1(fs_out1), .o_out2(fs_out2),
        .o_out_valid(fs_out_valid), .i_out_ready(fs_out_ready), .o_pair_cnt(fs_pair_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every hand-off must match the oldest pushed pair
    always @(negedge clk) begin
        #1;
        if (!rst && !flush && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_pair", {out1, out2}, 16'hxxxx);
            end else begin
                pair_t e;
                e = q.pop_front();
                chk("pair_data", {out1, out2}, {e.a, e.b});
                chk("pair_cnt_at_handoff", pair_cnt, m_cnt);
                m_cnt = m_cnt + 4'd1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; fs_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = '0;
        q.delete();
    endtask

    task automatic send(input logic [7:0] w);
        logic rdy;
        rdy = 1'b0;
        @(negedge clk);
        in_w = w; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            stalls++;
            @(negedge clk);
        end
        chk("send_accept", {31'd0, rdy}, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        #1;
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_out1"}, out1, 0);
        chk({tag, "_out2"}, out2, 0);
        chk({tag, "_pair_cnt"}, pair_cnt, 0);
        chk({tag, "_sel"}, {31'd0, sel}, 0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{8'hF0, 8'hCC, 4'd1};
        tbl[1] = '{8'h01, 8'h02, 4'd2};
        tbl[2] = '{8'h03, 8'h04, 4'd3};
        tbl[3] = '{8'h05, 8'h06, 4'd4};
        tbl[4] = '{8'h07, 8'h08, 4'd5};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_w = '0; out_ready = 1'b1;
        fs_in = '0; fs_in_valid = 1'b0; fs_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // FIRST_SEL=1 instance: F0 lands in out2, CC in out1
        chk("fs_reset_sel", {31'd0, fs_sel}, 1);
        @(negedge clk); fs_in = 8'hF0; fs_in_valid = 1'b1;
        @(negedge clk); fs_in = 8'hCC;
        #1 chk("fs_sel_wait_b", {31'd0, fs_sel}, 0);
        @(negedge clk); fs_in_valid = 1'b0;
        #1;
        chk("fs_out_valid", {31'd0, fs_out_valid}, 1);
        chk("fs_out2", fs_out2, 8'hF0);
        chk("fs_out1", fs_out1, 8'hCC);
        @(negedge clk); #1;
        chk("fs_out_valid_drop", {31'd0, fs_out_valid}, 0);
        chk("fs_pair_cnt", fs_pair_cnt, 1);

        // back-to-back stream, consumer always ready: no stalls allowed
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            q.push_back('{tbl[i].a, tbl[i].b});
            send(tbl[i].a);
            send(tbl[i].b);
        end
        idle();
        drain();
        #1;
        chk("stream_stalls", stalls, 0);
        chk("stream_pair_cnt", pair_cnt, tbl[4].exp_cnt);

        // backpressure: pair held, next word refused until hand-off
        out_ready = 1'b0;
        q.push_back('{8'hAA, 8'h55});
        send(8'hAA);
        send(8'h55);
        @(negedge clk); in_w = 8'h11;
        #1 chk("latency_out_valid", {31'd0, out_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("hold_in_ready", {31'd0, in_ready}, 0);
            chk("hold_out1", out1, 8'hAA);
            chk("hold_out2", out2, 8'h55);
        end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        #1;
        chk("passthru_sel", {31'd0, sel}, 1);
        chk("passthru_out1", out1, 8'h11);
        q.push_back('{8'h11, 8'h22});
        send(8'h22);
        idle();
        drain();

        // flush drops the partial 3C and returns to the first lane
        send(8'h3C);
        @(negedge clk); in_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1;
        chk("flush_sel", {31'd0, sel}, 0);
        chk("flush_out_valid", {31'd0, out_valid}, 0);
        chk("flush_pair_cnt", pair_cnt, 4'd7);
        q.push_back('{8'h7E, 8'h81});
        send(8'h7E);
        send(8'h81);
        idle();
        drain();

        // reset mid-pair, then reset with a pair waiting
        send(8'h5A);
        do_reset();
        check_reset_state("rst_wait_b");
        out_ready = 1'b0;
        send(8'hA1);
        send(8'hB2);
        idle();
        #1 chk("pre_rst_full", {31'd0, out_valid}, 1);
        do_reset();
        check_reset_state("rst_full");

        // 17 pairs through a 4-bit counter wraps to 1
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            q.push_back('{8'(i), ~8'(i)});
            send(8'(i));
            send(~8'(i));
        end
        idle();
        drain();
        #1 chk("wrap_pair_cnt", pair_cnt, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

endmodule
